// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath: decodes op/funct and drives
// every select and write enable, one state per cycle.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       iord,
    output logic       mem_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       reg_write_addr,
    output logic       reg_write_data,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [2:0] alu_controller,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   is_store;   // lw/sw choice remembered from DECODE; op is not sampled in MEMADR
    logic   rt_bad;     // unsupported funct seen in RTEXEC, blocks the RTWB write
    logic   funct_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= state_t'(RESET_STATE);
            is_store <= 1'b0;
            rt_bad   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) is_store <= (op == OP_SW);
            if (state_q == RTEXEC) rt_bad   <= ~funct_ok;
        end
    end

    always_comb begin
        state_d        = FETCH;
        pc_we          = 1'b0;
        iord           = 1'b0;
        mem_we         = 1'b0;
        ir_we          = 1'b0;
        reg_we         = 1'b0;
        reg_write_addr = 1'b0;
        reg_write_data = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        imm_zext       = 1'b0;
        alu_controller = 3'b000;
        pc_src         = 2'b00;
        illegal_op     = 1'b0;
        case (state_q)
            FETCH: begin
                state_d        = DECODE;
                ir_we          = 1'b1;
                alu_src_b      = 2'b01;
                alu_controller = ALU_ADD;
                pc_we          = 1'b1;
            end
            DECODE: begin
                alu_src_b      = 2'b11;
                alu_controller = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:                      state_d = MEMADR;
                    OP_RTYPE:                          state_d = (funct == FN_JR) ? JR : RTEXEC;
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
                    OP_J:                              state_d = JUMP;
                    default:                           illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                state_d        = is_store ? MEMWR : MEMRD;
                alu_src_a      = 1'b1;
                alu_src_b      = 2'b10;
                alu_controller = ALU_ADD;
            end
            MEMRD: begin
                state_d = MEMWB;
                iord    = 1'b1;
            end
            MEMWB: begin
                reg_we         = 1'b1;
                reg_write_data = 1'b1;
            end
            MEMWR: begin
                iord   = 1'b1;
                mem_we = 1'b1;
            end
            RTEXEC: begin
                state_d        = RTWB;
                alu_src_a      = 1'b1;
                alu_controller = funct_alu;
                illegal_op     = ~funct_ok;
            end
            RTWB: begin
                reg_we         = ~rt_bad;
                reg_write_addr = 1'b1;
            end
            BRANCH: begin
                alu_src_a      = 1'b1;
                alu_controller = ALU_SUB;
                pc_src         = 2'b01;
                pc_we          = (op == OP_BNE) ? ~zero : zero;
            end
            IEXEC: begin
                state_d   = IWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    OP_ANDI: begin alu_controller = ALU_AND; imm_zext = 1'b1; end
                    OP_ORI:  begin alu_controller = ALU_OR;  imm_zext = 1'b1; end
                    OP_SLTI: alu_controller = ALU_SLT;
                    default: alu_controller = ALU_ADD;
                endcase
            end
            IWB:  reg_we = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            JR: begin
                pc_src = 2'b11;
                pc_we  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Reset wins over decode so an abandoned instruction cannot write anything.
        if (rst) begin
            pc_we      = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases then a random instruction
// stream, checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_we, iord, mem_we, ir_we, reg_we, reg_write_addr, reg_write_data;
    logic       alu_src_a, imm_zext, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_controller;
    logic [3:0] state;

    int passes = 0;
    int checks = 0;

    typedef int iq_t[$];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we), .iord(iord), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .alu_controller(alu_controller), .pc_src(pc_src), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_we,iord,mem_we,ir_we,reg_we,wr_addr,wr_data,src_a,src_b,zext,alu,pc_src,illegal}
    function automatic logic [16:0] pack(logic pw, logic io, logic mw, logic iw, logic rw,
                                         logic wa, logic wd, logic sa, logic [1:0] sb,
                                         logic zx, logic [2:0] alu, logic [1:0] ps, logic il);
        return {pw, io, mw, iw, rw, wa, wd, sa, sb, zx, alu, ps, il};
    endfunction

    function automatic logic [16:0] dut_out();
        return pack(pc_we, iord, mem_we, ir_we, reg_we, reg_write_addr, reg_write_data,
                    alu_src_a, alu_src_b, imm_zext, alu_controller, pc_src, illegal_op);
    endfunction

    localparam logic [16:0] EN_MASK = pack(1,0,1,1,1,0,0,0,2'b00,0,3'b000,2'b00,1);

    function automatic int rfunct_alu(logic [5:0] f);   // -1 when unsupported
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return -1;
        endcase
    endfunction

    // State walk of one instruction, FETCH first.
    function automatic iq_t path_of(logic [5:0] o, logic [5:0] f);
        case (o)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: return (f == 6'b001000) ? '{0, 1, 12} : '{0, 1, 6, 7};
            6'b000100, 6'b000101: return '{0, 1, 8};
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return '{0, 1, 9, 10};
            6'b000010: return '{0, 1, 11};
            default: return '{0, 1};
        endcase
    endfunction

    // Expected outputs in a given step of an instruction.
    function automatic logic [16:0] exp_out(int st, logic [5:0] o, logic [5:0] f, logic z);
        int fa;
        fa = rfunct_alu(f);
        case (st)
            0:  return pack(1,0,0,1,0,0,0,0,2'b01,0,3'b010,2'b00,0);
            1:  return pack(0,0,0,0,0,0,0,0,2'b11,0,3'b010,2'b00,
                            (path_of(o, f).size() == 2) ? 1'b1 : 1'b0);
            2:  return pack(0,0,0,0,0,0,0,1,2'b10,0,3'b010,2'b00,0);
            3:  return pack(0,1,0,0,0,0,0,0,2'b00,0,3'b000,2'b00,0);
            4:  return pack(0,0,0,0,1,0,1,0,2'b00,0,3'b000,2'b00,0);
            5:  return pack(0,1,1,0,0,0,0,0,2'b00,0,3'b000,2'b00,0);
            6:  return pack(0,0,0,0,0,0,0,1,2'b00,0,(fa < 0) ? 3'b000 : 3'(fa),2'b00,
                            (fa < 0) ? 1'b1 : 1'b0);
            7:  return pack(0,0,0,0,(fa >= 0) ? 1'b1 : 1'b0,1,0,0,2'b00,0,3'b000,2'b00,0);
            8:  return pack((o == 6'b000101) ? ~z : z,0,0,0,0,0,0,1,2'b00,0,3'b110,2'b01,0);
            9:  begin
                case (o)
                    6'b001100: return pack(0,0,0,0,0,0,0,1,2'b10,1,3'b000,2'b00,0);
                    6'b001101: return pack(0,0,0,0,0,0,0,1,2'b10,1,3'b001,2'b00,0);
                    6'b001010: return pack(0,0,0,0,0,0,0,1,2'b10,0,3'b111,2'b00,0);
                    default:   return pack(0,0,0,0,0,0,0,1,2'b10,0,3'b010,2'b00,0);
                endcase
            end
            10: return pack(0,0,0,0,1,0,0,0,2'b00,0,3'b000,2'b00,0);
            11: return pack(1,0,0,0,0,0,0,0,2'b00,0,3'b000,2'b10,0);
            12: return pack(1,0,0,0,0,0,0,0,2'b00,0,3'b000,2'b11,0);
            default: return '0;
        endcase
    endfunction

    task automatic check(string tag, logic [16:0] got, logic [16:0] want);
        checks++;
        assert (got === want) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %05h expected %05h", tag, got, want);
        end
    endtask

    task automatic check_state(string tag, logic [3:0] want);
        checks++;
        assert (state === want) begin
            passes++;
        end else begin
            $error("FAIL %s: observed state %0d expected %0d", tag, state, want);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(string tag, logic [5:0] o, logic [5:0] f, logic z);
        iq_t p;
        op = o; funct = f; zero = z;
        p = path_of(o, f);
        foreach (p[i]) begin
            #1;
            check_state(tag, 4'(p[i]));
            check(tag, dut_out(), exp_out(p[i], o, f, z));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] fns [7];
        logic [5:0] o, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000, 6'b000000};

        rst = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_state("reset_state", 4'd0);
        check("reset_enables", dut_out() & EN_MASK, 17'd0);
        rst = 1'b0;
        #1;
        check("first_fetch", {pc_we, ir_we, alu_src_b}, {13'd0, 1'b1, 1'b1, 2'b01});

        run_instr("lw",       6'b100011, 6'b000000, 1'b0);
        run_instr("sw",       6'b101011, 6'b000000, 1'b0);
        run_instr("r_sub",    6'b000000, 6'b100010, 1'b0);
        run_instr("jr",       6'b000000, 6'b001000, 1'b0);
        run_instr("beq_t",    6'b000100, 6'b000000, 1'b1);
        run_instr("beq_nt",   6'b000100, 6'b000000, 1'b0);
        run_instr("bne_t",    6'b000101, 6'b000000, 1'b0);
        run_instr("bne_nt",   6'b000101, 6'b000000, 1'b1);
        run_instr("ori",      6'b001101, 6'b000000, 1'b0);
        run_instr("j",        6'b000010, 6'b000000, 1'b0);
        run_instr("illegal",  6'b111111, 6'b000000, 1'b0);
        run_instr("bad_fn",   6'b000000, 6'b111100, 1'b0);

        // Reset while in MEMRD: next edge goes to FETCH and no register write follows.
        op = 6'b100011; funct = '0; zero = 1'b0;
        repeat (3) @(negedge clk);
        check_state("mid_rst_memrd", 4'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", dut_out() & EN_MASK, 17'd0);
        @(negedge clk);
        check_state("mid_rst_state", 4'd0);
        check("mid_rst_no_we", {16'd0, reg_we}, 17'd0);
        @(negedge clk);
        check("mid_rst_hold", {16'd0, reg_we}, 17'd0);
        rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            o = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            f = fns[$urandom_range(0, 6)];
            if (f == 6'b000000) f = 6'($urandom);
            run_instr("rand", o, f, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
